bp_update_scheduler: RTL and testbench

//  Sits between the M stage and the local branch predictor tables (per-PC BHT, shared PHT).

---
 rtl/bp_update_scheduler.sv | 137 +++++++++++++
 tb/tb_bp_update_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// Branch predictor update scheduler: post-reset table init sweep, then a small FIFO that
// serialises resolved-branch updates onto a single predictor write port. Optional macro: BP_STATS_EN.
module bp_update_scheduler #(
    parameter int BHT_DEPTH  = 10,
    parameter int PHT_DEPTH  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 branchM,
    input  logic                 actual_takeM,
    input  logic                 pred_takeM,
    input  logic [31:0]          pcM,
    input  logic                 upd_ready,
    output logic                 upd_valid,
    output logic [BHT_DEPTH-1:0] upd_index,
    output logic                 upd_take,
    output logic                 init_we,
    output logic [BHT_DEPTH-1:0] init_index,
    output logic                 init_busy,
    output logic [15:0]          drop_cnt,
`ifdef BP_STATS_EN
    output logic [31:0]          br_cnt,
    output logic [31:0]          mispred_cnt,
`endif
    output logic                 dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = BHT_DEPTH + 1;
    localparam logic PHT_FITS = (PHT_DEPTH <= BHT_DEPTH);

    // Handshake: the head entry is offered while upd_valid is high and is consumed on any
    // cycle where upd_valid & upd_ready; it holds stable otherwise.

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [BHT_DEPTH-1:0] sweep_q, sweep_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [15:0]          drop_q, drop_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic                 empty, full, running, push, pop, drop;

    // Pieces of pcM outside the index, and pred_takeM in the default build, are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{pcM[31:BHT_DEPTH+2], pcM[1:0], pred_takeM, PHT_FITS};

    assign running = (state_q == ST_RUN);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    assign upd_valid = running && !empty;
    assign upd_index = upd_valid ? head[EW-1:1] : '0;
    assign upd_take  = upd_valid & head[0];
    assign drop_cnt  = drop_q;
    assign dbg_state_o = state_q;

    assign pop  = upd_valid && upd_ready;
    assign push = running && branchM && (!full || pop);
    assign drop = running && branchM && full && !pop;

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        init_we    = 1'b0;
        init_busy  = 1'b0;
        init_index = '0;
        case (state_q)
            ST_INIT: begin
                init_we    = 1'b1;
                init_busy  = 1'b1;
                init_index = sweep_q;
                sweep_d    = sweep_q + 1'b1;
                if (sweep_q == {BHT_DEPTH{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            sweep_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {pcM[BHT_DEPTH+1:2], actual_takeM};
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_q, mis_q;
    assign br_cnt      = br_q;
    assign mispred_cnt = mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_q  <= '0;
            mis_q <= '0;
        end else if (running && branchM) begin
            br_q <= br_q + 32'd1;
            if (pred_takeM != actual_takeM) mis_q <= mis_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed self-checking bench for bp_update_scheduler (BHT_DEPTH=4, FIFO_DEPTH=4).
module tb_bp_update_scheduler;

    localparam int BHT = 4;
    localparam int FD  = 4;
    localparam int W   = BHT + 1;

    logic           clk = 1'b0;
    logic           rst, branchM, actual_takeM, pred_takeM, upd_ready;
    logic [31:0]    pcM;
    logic           upd_valid, upd_take, init_we, init_busy, dbg_state;
    logic [BHT-1:0] upd_index, init_index;
    logic [15:0]    drop_cnt;
`ifdef BP_STATS_EN
    logic [31:0]    br_cnt, mispred_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    bp_update_scheduler #(.BHT_DEPTH(BHT), .PHT_DEPTH(2), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .branchM(branchM), .actual_takeM(actual_takeM),
        .pred_takeM(pred_takeM), .pcM(pcM), .upd_ready(upd_ready),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_take(upd_take),
        .init_we(init_we), .init_index(init_index), .init_busy(init_busy),
        .drop_cnt(drop_cnt),
`ifdef BP_STATS_EN
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt),
`endif
        .dbg_state_o(dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic take, input logic pred);
        branchM      = 1'b1;
        pcM          = pc;
        actual_takeM = take;
        pred_takeM   = pred;
    endtask

    task automatic idle_br();
        branchM      = 1'b0;
        pcM          = '0;
        actual_takeM = 1'b0;
        pred_takeM   = 1'b0;
    endtask

    // Reset, then walk the whole sweep checking every index with branches held high.
    task automatic reset_and_sweep();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_br(32'h0000_0FFC, 1'b1, 1'b0);
        for (int i = 0; i < (1 << BHT); i++) begin
            check("sweep_we", {31'd0, init_we}, 32'd1);
            check("sweep_idx", {28'd0, init_index}, i);
            check("sweep_valid", {31'd0, upd_valid}, 32'd0);
            step();
        end
        idle_br();
        check("run_busy", {31'd0, init_busy}, 32'd0);
        check("run_we", {31'd0, init_we}, 32'd0);
        check("run_idx", {28'd0, init_index}, 32'd0);
        check("run_state", {31'd0, dbg_state}, 32'd1);
        check("run_valid", {31'd0, upd_valid}, 32'd0);
        check("run_drop", {16'd0, drop_cnt}, 32'd0);
    endtask

    // scoreboard compare of the queue head
    task automatic check_head(input string tag);
        exp_e = exp_q.pop_front();
        check({tag, "_valid"}, {31'd0, upd_valid}, 32'd1);
        check({tag, "_idx"}, {28'd0, upd_index}, {28'd0, exp_e[W-1:1]});
        check({tag, "_take"}, {31'd0, upd_take}, {31'd0, exp_e[0]});
    endtask

    function automatic logic [W-1:0] entry(input logic [31:0] pc, input logic take);
        return {pc[BHT+1:2], take};
    endfunction

    logic [31:0] pcs   [6] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0208,
                               32'h0000_030C, 32'h0000_0410, 32'h0000_0514};
    logic        takes [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        upd_ready = 1'b1;
        idle_br();
        step();
        // reset values while rst is still high
        check("rst_valid", {31'd0, upd_valid}, 32'd0);
        check("rst_idx", {28'd0, upd_index}, 32'd0);
        check("rst_take", {31'd0, upd_take}, 32'd0);
        check("rst_we", {31'd0, init_we}, 32'd1);
        check("rst_iidx", {28'd0, init_index}, 32'd0);
        check("rst_busy", {31'd0, init_busy}, 32'd1);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);

        // 1: sweep of exactly 16 cycles, branches during INIT ignored
        reset_and_sweep();
`ifdef BP_STATS_EN
        check("init_br_cnt", br_cnt, 32'd0);
        check("init_mis_cnt", mispred_cnt, 32'd0);
`endif

        // 2: single update, pc 0x44 -> index 1 at BHT_DEPTH=4 (17 at BHT_DEPTH=10)
        upd_ready = 1'b1;
        drive_br(32'h0000_0044, 1'b1, 1'b1);
        check("nofall_valid", {31'd0, upd_valid}, 32'd0);
        step();
        idle_br();
        check("t2_valid", {31'd0, upd_valid}, 32'd1);
        check("t2_idx", {28'd0, upd_index}, 32'd1);
        check("t2_take", {31'd0, upd_take}, 32'd1);
        step();
        check("t2_gone", {31'd0, upd_valid}, 32'd0);

        // 3: six branches into a 4-deep queue with no ready -> 2 drops
        upd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_br(pcs[i], takes[i], 1'b0);
            if (i < FD) exp_q.push_back(entry(pcs[i], takes[i]));
            step();
        end
        idle_br();
        check("t3_drop", {16'd0, drop_cnt}, 32'd2);
        check("t3_hold_idx", {28'd0, upd_index}, {28'd0, exp_q[0][W-1:1]});
        step();
        check("t3_hold_idx2", {28'd0, upd_index}, {28'd0, exp_q[0][W-1:1]});
        upd_ready = 1'b1;
        for (int i = 0; i < FD; i++) begin
            check_head("t3_drain");
            step();
        end
        check("t3_empty", {31'd0, upd_valid}, 32'd0);

        // 4: full queue with push+pop every cycle for 10 cycles
        upd_ready = 1'b0;
        for (int i = 0; i < FD; i++) begin
            drive_br(32'h0000_1000 + (i << 2), i[0], 1'b0);
            exp_q.push_back(entry(32'h0000_1000 + (i << 2), i[0]));
            step();
        end
        upd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_br(32'h0000_2000 + ((i + 5) << 2), ~i[1], 1'b0);
            check_head("t4_flow");
            exp_q.push_back(entry(32'h0000_2000 + ((i + 5) << 2), ~i[1]));
            step();
        end
        idle_br();
        for (int i = 0; i < FD; i++) begin
            check_head("t4_drain");
            step();
        end
        check("t4_empty", {31'd0, upd_valid}, 32'd0);
        check("t4_drop", {16'd0, drop_cnt}, 32'd2);

        // 5: reset mid-drain with 3 queued
        upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_br(32'h0000_3000 + (i << 2), 1'b1, 1'b0);
            step();
        end
        idle_br();
        upd_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("t5_valid", {31'd0, upd_valid}, 32'd0);
        check("t5_busy", {31'd0, init_busy}, 32'd1);
        check("t5_iidx", {28'd0, init_index}, 32'd0);
        check("t5_drop", {16'd0, drop_cnt}, 32'd0);
        exp_q.delete();
        reset_and_sweep();

        // 6: five branches, two mispredicted; stale entries must not reappear
        upd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_br(32'h0000_0040 + (i << 2), i[0], (i == 1 || i == 4) ? ~i[0] : i[0]);
            step();
            check("t6_valid", {31'd0, upd_valid}, 32'd1);
            check("t6_idx", {28'd0, upd_index}, i[3:0] + 32'd0);
        end
        idle_br();
        step();
        check("t6_empty", {31'd0, upd_valid}, 32'd0);
`ifdef BP_STATS_EN
        check("t6_br_cnt", br_cnt, 32'd5);
        check("t6_mis_cnt", mispred_cnt, 32'd2);
`endif

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
